flash_spi_reader: RTL and testbench
===================================

Name: flash_spi_reader

Overview:
- SPI master for the FPGA configuration flash. It consumes the byte-level flash request signals driven by the STM32 bus interface (FLASH_enable, FLASH_continue_read, FLASH_data_out) and returns FLASH_data_in and FLASH_busy.
- Each request shifts one byte out on MOSI while shifting one byte in from MISO, SPI mode 0, MSB first.
- Chip select is held low across consecutive bytes until FLASH_enable drops. The STM32 can therefore issue a read command, an address and then an arbitrary-length stream of data reads.

Parameters:
- CLK_DIV, 2, clk_in cycles per SCK half-period (≥1); SCK = clk_in/(2*CLK_DIV).
- CS_SETUP, 2, clk_in cycles from NCS falling to first SCK low-phase start (≥1).
- CS_HIGH_MIN, 4, minimum clk_in cycles NCS stays high after a transaction ends (≥1).

Ports:
- clk_in  in  1  system clock (same domain as bus interface)
- reset  in  1  synchronous, active-high reset
- FLASH_enable  in  1  level; rising edge starts transaction + first byte; low ends transaction
- FLASH_continue_read  in  1  one-cycle pulse; request next byte within open transaction
- FLASH_data_out  in  8  byte to transmit, sampled on start/continue cycle
- FLASH_data_in  out  8  last received byte
- FLASH_busy  out  1  byte transfer pending/in progress
- FLASH_NCS  out  1  flash chip select, active low
- FLASH_DCLK  out  1  SPI clock
- FLASH_ASDO  out  1  MOSI
- FLASH_DATA0  in  1  MISO (synchronised externally)

Behaviour:
- Reset (synchronous, active-high): state IDLE, NCS=1, DCLK=0, ASDO=0, FLASH_data_in=0, busy=0, enable_d=0, counters 0. Takes effect from any state, mid-byte included; no partial byte is written to FLASH_data_in.
- start = FLASH_enable & ~enable_d (enable_d is enable registered every cycle). cont = FLASH_continue_read & FLASH_enable.
- FLASH_busy = (state ∉ {IDLE, HOLD, CS_HIGH}) | (state==IDLE & start) | (state==HOLD & cont). The bus interface samples busy one cycle after issuing a request, so busy must be combinationally high in the request cycle.
- States and transitions:
  - IDLE: NCS=1. On start, latch FLASH_data_out into shift_tx, drive NCS=0 and go to SETUP.
  - SETUP: NCS=0, DCLK=0, ASDO=shift_tx[7]. Lasts CS_SETUP cycles, then LOW.
  - LOW: DCLK=0 for CLK_DIV cycles, then HIGH. On this transition DCLK goes 1 and shift_rx <= {shift_rx[6:0], FLASH_DATA0}.
  - HIGH: DCLK=1 for CLK_DIV cycles. If fewer than 8 bits are done: DCLK goes 0, shift_tx shifts left, ASDO takes the next bit, go to LOW. After bit 8: DCLK goes 0, FLASH_data_in <= shift_rx, go to HOLD.
  - HOLD: NCS=0, DCLK=0. On cont, latch FLASH_data_out and go to LOW (no extra setup). On FLASH_enable==0, go to CS_HIGH.
  - CS_HIGH: NCS=1 for CS_HIGH_MIN cycles, then IDLE. Starts requested during CS_HIGH are not accepted.
- Byte latency: request cycle to busy low is CS_SETUP+16*CLK_DIV cycles for the first byte and 16*CLK_DIV for continue bytes. FLASH_data_in is valid in the same cycle busy falls and holds until the next byte completes.
- FLASH_enable low in SETUP/LOW/HIGH aborts immediately: next cycle NCS=1, DCLK=0, FLASH_data_in unchanged, go to CS_HIGH.
- cont while busy, or while in IDLE/CS_HIGH, is ignored.
- start and cont in the same cycle are treated as start.
- An enable edge that occurs during CS_HIGH counts as a start once the block reaches IDLE, provided enable is still high. The edge detector is gated so this pending start is honoured.
- Counters are sized ≥ clog2 of the largest parameter value.

Test Plan:
- Defaults, start with FLASH_data_out=0x03, slave drives 0xA5 -> busy high exactly 34 cycles starting in the request cycle; NCS low; 8 DCLK pulses of 2 high/2 low; ASDO sequence 0,0,0,0,0,0,1,1; FLASH_data_in=0xA5 when busy falls.
- After the first byte, three cont pulses spaced 40 cycles apart, slave returns 0x3C, 0xFF, 0x00 -> NCS stays low throughout; each byte takes 32 busy cycles; FLASH_data_in steps 0x3C, 0xFF, 0x00.
- FLASH_enable dropped after the 4th rising DCLK edge of a byte -> NCS=1 and DCLK=0 next cycle; busy=0; FLASH_data_in keeps its prior value; NCS stays high for ≥4 cycles.
- cont pulse 10 cycles into a busy byte -> ignored: exactly 8 DCLK pulses, no second byte.
- reset asserted mid-byte (bit 5) -> next cycle NCS=1, DCLK=0, ASDO=0, busy=0, FLASH_data_in=0x00. A new start afterwards completes normally with FLASH_data_in=0xA5.
- Enable low for 1 cycle, then high again -> NCS high for ≥4 cycles, then a new transaction starts without a further enable edge.

Source files
------------

// File: rtl/flash_spi_reader_if.sv
// Byte-level request bus between the STM32 bus interface (master) and the
// configuration-flash SPI reader (slave).
interface flash_spi_reader_if;
   logic       FLASH_enable;
   logic       FLASH_continue_read;
   logic [7:0] FLASH_data_out;
   logic [7:0] FLASH_data_in;
   logic       FLASH_busy;

   modport master (
      output FLASH_enable,
      output FLASH_continue_read,
      output FLASH_data_out,
      input  FLASH_data_in,
      input  FLASH_busy
   );

   modport slave (
      input  FLASH_enable,
      input  FLASH_continue_read,
      input  FLASH_data_out,
      output FLASH_data_in,
      output FLASH_busy
   );
endinterface

// File: rtl/flash_spi_reader.sv
// SPI mode-0 master for the configuration flash: one byte out/in per request,
// chip select held low across bytes until FLASH_enable drops.
module flash_spi_reader #(
   parameter int unsigned CLK_DIV     = 2,
   parameter int unsigned CS_SETUP    = 2,
   parameter int unsigned CS_HIGH_MIN = 4
) (
   input  logic                 clk_in,
   input  logic                 reset,
   flash_spi_reader_if.slave    bus,
   output logic                 FLASH_NCS,
   output logic                 FLASH_DCLK,
   output logic                 FLASH_ASDO,
   input  logic                 FLASH_DATA0
);

   localparam int unsigned MAX_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
   localparam int unsigned MAX_P = (MAX_A > CS_HIGH_MIN) ? MAX_A : CS_HIGH_MIN;
   localparam int unsigned CW    = $clog2(MAX_P + 1);

   localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
   localparam logic [CW-1:0] CSH_LAST   = CW'(CS_HIGH_MIN - 1);
   // The cycle before a byte's first low phase (last SETUP cycle or the
   // request cycle in HOLD) already has DCLK low, so it counts toward it.
   localparam logic [CW-1:0] LOW_PRELOAD = (CLK_DIV > 1) ? CW'(1) : CW'(0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_LOW,
      S_HIGH,
      S_HOLD,
      S_CS_HIGH
   } state_t;

   state_t        state_q, state_n;
   logic [CW-1:0] cnt_q, cnt_n;
   logic [2:0]    bit_q, bit_n;
   logic [7:0]    tx_q, tx_n;
   logic [7:0]    rx_q, rx_n;
   logic [7:0]    data_in_q, data_in_n;
   logic          ncs_q, ncs_n;
   logic          dclk_q, dclk_n;
   logic          asdo_q, asdo_n;
   logic          enable_d_q, enable_d_n;

   logic start;
   logic cont;

   assign start = bus.FLASH_enable & ~enable_d_q;
   assign cont  = bus.FLASH_continue_read & bus.FLASH_enable;

   // NOTE: every signal written here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      state_n    = state_q;
      cnt_n      = cnt_q + 1'b1;
      bit_n      = bit_q;
      tx_n       = tx_q;
      rx_n       = rx_q;
      data_in_n  = data_in_q;
      ncs_n      = ncs_q;
      dclk_n     = dclk_q;
      asdo_n     = asdo_q;
      // Held low during CS_HIGH so an enable edge there becomes a pending start.
      enable_d_n = (state_q == S_CS_HIGH) ? 1'b0 : bus.FLASH_enable;

      unique case (state_q)
         S_IDLE: begin
            ncs_n  = 1'b1;
            dclk_n = 1'b0;
            cnt_n  = '0;
            if (start) begin
               tx_n    = bus.FLASH_data_out;
               asdo_n  = bus.FLASH_data_out[7];
               ncs_n   = 1'b0;
               bit_n   = '0;
               state_n = S_SETUP;
            end
         end

         S_SETUP: begin
            if (!bus.FLASH_enable) begin
               ncs_n   = 1'b1;
               dclk_n  = 1'b0;
               cnt_n   = '0;
               state_n = S_CS_HIGH;
            end else if (cnt_q == SETUP_LAST) begin
               cnt_n   = LOW_PRELOAD;
               state_n = S_LOW;
            end
         end

         S_LOW: begin
            if (!bus.FLASH_enable) begin
               ncs_n   = 1'b1;
               dclk_n  = 1'b0;
               cnt_n   = '0;
               state_n = S_CS_HIGH;
            end else if (cnt_q == DIV_LAST) begin
               dclk_n  = 1'b1;
               rx_n    = {rx_q[6:0], FLASH_DATA0};
               cnt_n   = '0;
               state_n = S_HIGH;
            end
         end

         S_HIGH: begin
            if (!bus.FLASH_enable) begin
               ncs_n   = 1'b1;
               dclk_n  = 1'b0;
               cnt_n   = '0;
               state_n = S_CS_HIGH;
            end else if (cnt_q == DIV_LAST) begin
               dclk_n = 1'b0;
               cnt_n  = '0;
               if (bit_q == 3'd7) begin
                  data_in_n = rx_q;
                  state_n   = S_HOLD;
               end else begin
                  bit_n   = bit_q + 3'd1;
                  tx_n    = {tx_q[6:0], 1'b0};
                  asdo_n  = tx_q[6];
                  state_n = S_LOW;
               end
            end
         end

         S_HOLD: begin
            ncs_n  = 1'b0;
            dclk_n = 1'b0;
            cnt_n  = '0;
            if (cont) begin
               tx_n    = bus.FLASH_data_out;
               asdo_n  = bus.FLASH_data_out[7];
               bit_n   = '0;
               cnt_n   = LOW_PRELOAD;
               state_n = S_LOW;
            end else if (!bus.FLASH_enable) begin
               ncs_n   = 1'b1;
               state_n = S_CS_HIGH;
            end
         end

         S_CS_HIGH: begin
            ncs_n  = 1'b1;
            dclk_n = 1'b0;
            if (cnt_q == CSH_LAST) begin
               cnt_n   = '0;
               state_n = S_IDLE;
            end
         end

         default: begin
            ncs_n   = 1'b1;
            dclk_n  = 1'b0;
            cnt_n   = '0;
            state_n = S_IDLE;
         end
      endcase
   end

   // NOTE: registered state uses non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         data_in_q  <= '0;
         ncs_q      <= 1'b1;
         dclk_q     <= 1'b0;
         asdo_q     <= 1'b0;
         enable_d_q <= 1'b0;
      end else begin
         state_q    <= state_n;
         cnt_q      <= cnt_n;
         bit_q      <= bit_n;
         tx_q       <= tx_n;
         rx_q       <= rx_n;
         data_in_q  <= data_in_n;
         ncs_q      <= ncs_n;
         dclk_q     <= dclk_n;
         asdo_q     <= asdo_n;
         enable_d_q <= enable_d_n;
      end
   end

   // Busy is combinational so the bus interface sees it in the request cycle.
   assign bus.FLASH_busy = ((state_q != S_IDLE) && (state_q != S_HOLD) && (state_q != S_CS_HIGH))
                         | ((state_q == S_IDLE) & start)
                         | ((state_q == S_HOLD) & cont);

   assign bus.FLASH_data_in = data_in_q;
   assign FLASH_NCS         = ncs_q;
   assign FLASH_DCLK        = dclk_q;
   assign FLASH_ASDO        = asdo_q;

endmodule

// File: tb/tb_flash_spi_reader.sv
// Self-checking bench for flash_spi_reader: table-driven byte stream, corner
// sequences (abort, ignored continue, reset, pending start) and random traffic.
module tb_flash_spi_reader;
   localparam int CLK_DIV     = 2;
   localparam int CS_SETUP    = 2;
   localparam int CS_HIGH_MIN = 4;
   localparam int FIRST_LEN   = CS_SETUP + 16 * CLK_DIV;
   localparam int CONT_LEN    = 16 * CLK_DIV;

   logic clk_in = 1'b0;
   logic reset  = 1'b1;
   logic ncs, dclk, asdo;
   logic miso   = 1'b0;

   flash_spi_reader_if bus ();

   flash_spi_reader #(
      .CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HIGH_MIN(CS_HIGH_MIN)
   ) dut (
      .clk_in(clk_in), .reset(reset), .bus(bus),
      .FLASH_NCS(ncs), .FLASH_DCLK(dclk), .FLASH_ASDO(asdo), .FLASH_DATA0(miso)
   );

   always #5 clk_in = ~clk_in;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic check_ge(input string name, input int act, input int min);
      checks++;
      if (act < min) begin
         failures++;
         $display("FAIL %s: got %0d expected at least %0d", name, act, min);
      end
   endtask

   // ---------------- bus monitor + SPI slave model (sampled on negedge) ----
   int         done_cnt = 0, busy_run = 0, last_busy_len = 0;
   int         pulses_byte = 0, last_pulses = 0, pulses_txn = 0;
   int         ncs_hi_run = 0, last_ncs_hi = 0, ncs_rise_cnt = 0;
   int         hi_min, hi_max, lo_min, lo_max, dclk_run = 0;
   logic [7:0] mosi_cap = 8'h00, last_mosi = 8'h00, last_data = 8'h00;
   logic       busy_p = 1'b0, dclk_p = 1'b0, ncs_p = 1'b1;
   logic [7:0] slave_q[$];
   logic [7:0] cur = 8'h00;
   int         idx = 0;
   bit         loaded = 0;

   task automatic clear_stats();
      hi_min = 1000; hi_max = 0; lo_min = 1000; lo_max = 0;
   endtask

   initial begin
      clear_stats();
      forever begin
         @(negedge clk_in);
         if (bus.FLASH_busy) busy_run++;
         else begin
            if (busy_p && !ncs) begin
               done_cnt++;
               last_busy_len = busy_run;
               last_data     = bus.FLASH_data_in;
               last_mosi     = mosi_cap;
               last_pulses   = pulses_byte;
               pulses_byte   = 0;
            end
            busy_run = 0;
         end
         busy_p = bus.FLASH_busy;

         if (ncs) begin
            if (!ncs_p) ncs_rise_cnt++;
            ncs_hi_run++;
         end else begin
            if (ncs_p) begin
               last_ncs_hi = ncs_hi_run;
               pulses_txn  = 0;
               pulses_byte = 0;
            end
            ncs_hi_run = 0;
         end
         ncs_p = ncs;

         if (dclk != dclk_p) begin
            if (dclk) begin
               if (pulses_byte > 0) begin
                  if (dclk_run < lo_min) lo_min = dclk_run;
                  if (dclk_run > lo_max) lo_max = dclk_run;
               end
               pulses_byte++;
               pulses_txn++;
               mosi_cap = {mosi_cap[6:0], asdo};
            end else begin
               if (dclk_run < hi_min) hi_min = dclk_run;
               if (dclk_run > hi_max) hi_max = dclk_run;
            end
            dclk_run = 1;
         end else dclk_run++;

         // Mode-0 slave: first bit on NCS fall, next bit after each DCLK fall.
         if (ncs) loaded = 0;
         else if (!loaded) begin
            cur = 8'h00;
            if (slave_q.size() > 0) cur = slave_q.pop_front();
            idx    = 0;
            loaded = 1;
         end else if (dclk_p && !dclk) begin
            if (idx == 7) begin
               cur = 8'h00;
               if (slave_q.size() > 0) cur = slave_q.pop_front();
               idx = 0;
            end else idx++;
         end
         miso   = cur[7-idx];
         dclk_p = dclk;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- driver helpers ----------------
   task automatic step();
      @(posedge clk_in);
      #1;
      cyc++;
   endtask

   task automatic wait_done(input int prev, input string name);
      for (int i = 0; i < 300 && done_cnt == prev; i++) step();
      check({name, " completed"}, done_cnt - prev, 1);
   endtask

   task automatic check_byte(input string name, input logic [7:0] tx, input logic [7:0] rx,
                             input int len);
      check({name, " data_in"}, last_data, rx);
      check({name, " mosi"}, last_mosi, tx);
      check({name, " busy_len"}, last_busy_len, len);
      check({name, " dclk_pulses"}, last_pulses, 8);
   endtask

   typedef struct {
      bit         is_cont;
      logic [7:0] tx;
      logic [7:0] slave_byte;
      logic [7:0] exp_data;
      int         exp_len;
   } vec_t;

   vec_t vec[4];

   initial begin
      int         prev, rises0, req_cyc, nb;
      logic [7:0] rtx[4];
      logic [7:0] rrx[4];

      vec[0] = '{1'b0, 8'h03, 8'hA5, 8'hA5, 34};
      vec[1] = '{1'b1, 8'h9B, 8'h3C, 8'h3C, 32};
      vec[2] = '{1'b1, 8'h5A, 8'hFF, 8'hFF, 32};
      vec[3] = '{1'b1, 8'h81, 8'h00, 8'h00, 32};

      bus.FLASH_enable        = 1'b0;
      bus.FLASH_continue_read = 1'b0;
      bus.FLASH_data_out      = 8'h00;
      reset = 1'b1;
      repeat (3) step();
      check("reset ncs", ncs, 1);
      check("reset dclk", dclk, 0);
      check("reset asdo", asdo, 0);
      check("reset busy", bus.FLASH_busy, 0);
      check("reset data_in", bus.FLASH_data_in, 0);
      reset = 1'b0;
      repeat (2) step();

      // ---- table-driven stream: first byte then three continues ----
      clear_stats();
      rises0 = ncs_rise_cnt;
      for (int i = 0; i < 4; i++) slave_q.push_back(vec[i].slave_byte);
      for (int i = 0; i < 4; i++) begin
         prev = done_cnt;
         req_cyc = cyc;
         bus.FLASH_data_out = vec[i].tx;
         if (vec[i].is_cont) bus.FLASH_continue_read = 1'b1;
         else bus.FLASH_enable = 1'b1;
         #1 check($sformatf("vec%0d busy_in_request", i), bus.FLASH_busy, 1);
         step();
         bus.FLASH_continue_read = 1'b0;
         wait_done(prev, $sformatf("vec%0d", i));
         check_byte($sformatf("vec%0d", i), vec[i].tx, vec[i].exp_data, vec[i].exp_len);
         for (int k = 0; k < 100 && (cyc - req_cyc) < 40; k++) step();
      end
      check("stream ncs_stayed_low", ncs_rise_cnt - rises0, 0);
      check("stream dclk_hi_min", hi_min, CLK_DIV);
      check("stream dclk_hi_max", hi_max, CLK_DIV);
      check("stream dclk_lo_min", lo_min, CLK_DIV);
      check("stream dclk_lo_max", lo_max, CLK_DIV);
      bus.FLASH_enable = 1'b0;
      repeat (8) step();
      check("stream end ncs", ncs, 1);
      check_ge("stream end ncs_high", ncs_hi_run, CS_HIGH_MIN);

      // ---- abort after 4th rising DCLK edge ----
      slave_q.push_back(8'h77);
      prev = done_cnt;
      pulses_txn = 0;
      bus.FLASH_data_out = 8'h96;
      bus.FLASH_enable   = 1'b1;
      for (int i = 0; i < 200 && pulses_txn < 4; i++) step();
      check("abort reached 4 pulses", pulses_txn, 4);
      bus.FLASH_enable = 1'b0;
      step();
      check("abort ncs", ncs, 1);
      check("abort dclk", dclk, 0);
      check("abort busy", bus.FLASH_busy, 0);
      check("abort data_in kept", bus.FLASH_data_in, 8'h00);
      repeat (6) step();
      check_ge("abort ncs_high", ncs_hi_run, CS_HIGH_MIN);
      check("abort no byte done", done_cnt - prev, 0);
      slave_q.delete();

      // ---- continue pulse during a busy byte is ignored ----
      slave_q.push_back(8'h5A);
      prev = done_cnt;
      pulses_txn = 0;
      bus.FLASH_data_out = 8'hC3;
      bus.FLASH_enable   = 1'b1;
      step();
      repeat (9) step();
      bus.FLASH_data_out      = 8'h11;
      bus.FLASH_continue_read = 1'b1;
      step();
      bus.FLASH_continue_read = 1'b0;
      wait_done(prev, "ignored_cont");
      repeat (40) step();
      check("ignored_cont bytes", done_cnt - prev, 1);
      check("ignored_cont pulses", pulses_txn, 8);
      check("ignored_cont data_in", last_data, 8'h5A);
      check("ignored_cont mosi", last_mosi, 8'hC3);
      check("ignored_cont busy", bus.FLASH_busy, 0);
      bus.FLASH_enable = 1'b0;
      repeat (8) step();

      // ---- reset mid-byte ----
      slave_q.push_back(8'h6E);
      pulses_txn = 0;
      bus.FLASH_data_out = 8'h03;
      bus.FLASH_enable   = 1'b1;
      for (int i = 0; i < 200 && pulses_txn < 5; i++) step();
      check("midreset reached bit5", pulses_txn, 5);
      reset = 1'b1;
      bus.FLASH_enable = 1'b0;
      step();
      check("midreset ncs", ncs, 1);
      check("midreset dclk", dclk, 0);
      check("midreset asdo", asdo, 0);
      check("midreset busy", bus.FLASH_busy, 0);
      check("midreset data_in", bus.FLASH_data_in, 8'h00);
      reset = 1'b0;
      slave_q.delete();
      repeat (3) step();
      slave_q.push_back(8'hA5);
      prev = done_cnt;
      bus.FLASH_data_out = 8'h03;
      bus.FLASH_enable   = 1'b1;
      step();
      wait_done(prev, "after_reset");
      check_byte("after_reset", 8'h03, 8'hA5, FIRST_LEN);

      // ---- enable low for one cycle: pending start after CS_HIGH ----
      slave_q.push_back(8'h42);
      prev = done_cnt;
      bus.FLASH_data_out = 8'hE7;
      bus.FLASH_enable   = 1'b0;
      step();
      bus.FLASH_enable = 1'b1;
      wait_done(prev, "pending_start");
      check_byte("pending_start", 8'hE7, 8'h42, FIRST_LEN);
      check_ge("pending_start ncs_high", last_ncs_hi, CS_HIGH_MIN);

      // ---- random transactions against the byte-level model ----
      for (int t = 0; t < 10; t++) begin
         nb = $urandom_range(1, 4);
         for (int b = 0; b < nb; b++) begin
            rtx[b] = 8'($urandom);
            rrx[b] = 8'($urandom);
            slave_q.push_back(rrx[b]);
         end
         bus.FLASH_enable = 1'b0;
         repeat ($urandom_range(1, 8)) step();
         prev = done_cnt;
         bus.FLASH_data_out = rtx[0];
         bus.FLASH_enable   = 1'b1;
         step();
         wait_done(prev, $sformatf("rnd%0d.0", t));
         check_byte($sformatf("rnd%0d.0", t), rtx[0], rrx[0], FIRST_LEN);
         check_ge($sformatf("rnd%0d ncs_high", t), last_ncs_hi, CS_HIGH_MIN);
         for (int b = 1; b < nb; b++) begin
            repeat ($urandom_range(0, 5)) step();
            prev = done_cnt;
            bus.FLASH_data_out      = rtx[b];
            bus.FLASH_continue_read = 1'b1;
            step();
            bus.FLASH_continue_read = 1'b0;
            wait_done(prev, $sformatf("rnd%0d.%0d", t, b));
            check_byte($sformatf("rnd%0d.%0d", t, b), rtx[b], rrx[b], CONT_LEN);
         end
         slave_q.delete();
      end
      bus.FLASH_enable = 1'b0;
      repeat (10) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
